param_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO, successor to the fixed-flag FIFO in the verification env.

---
 rtl/param_sync_fifo.sv | 129 ++++++++++++
 tb/tb_param_sync_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO: any depth >= 2, programmable almost flags, fill level.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered read.
module param_sync_fifo #(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int AF_THRESH  = 7,
    parameter  int AE_THRESH  = 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [LVL_W-1:0]      level
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THRESH);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    // Explicit wrap keeps pointers valid for non power-of-2 depths.
    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        w_full  = (r_level == LVL_FULL);
        w_empty = (r_level == '0);
        w_wr_ok = wr_en & (~w_full | rd_en);
        w_rd_ok = rd_en & ~w_empty;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_wr_ack    <= w_wr_ok;
            r_overflow  <= wr_en & ~w_wr_ok;
            r_underflow <= rd_en & ~w_rd_ok;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always presented; rd_en only acknowledges it.
    always_comb begin
        data_out = r_mem[r_rd_ptr];
        rd_valid = ~w_empty;
    end
`else
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_rd_ok;
        end
    end

    always_comb begin
        data_out = r_data_out;
        rd_valid = r_rd_valid;
    end
`endif

    always_comb begin
        wr_ack      = r_wr_ack;
        overflow    = r_overflow;
        underflow   = r_underflow;
        full        = w_full;
        empty       = w_empty;
        almostfull  = (r_level >= LVL_AF);
        almostempty = ~w_empty & (r_level <= LVL_AE);
        level       = r_level;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a depth-8 instance (AF=6, AE=2) and a depth-5 instance.
// Expectations follow FIFO_FWFT_EN the same way the design does.
module tb_param_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        we8 = 1'b0, re8 = 1'b0;
    logic [15:0] din8 = '0, dout8;
    logic        vld8, ack8, ovf8, udf8, full8, emp8, af8, ae8;
    logic [3:0]  lvl8;

    logic        we5 = 1'b0, re5 = 1'b0;
    logic [15:0] din5 = '0, dout5;
    logic        vld5, ack5, ovf5, udf5, full5, emp5, af5, ae5;
    logic [2:0]  lvl5;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_d8 (
        .clk(clk), .rst(rst), .wr_en(we8), .data_in(din8), .rd_en(re8),
        .data_out(dout8), .rd_valid(vld8), .wr_ack(ack8), .overflow(ovf8),
        .underflow(udf8), .full(full8), .empty(emp8), .almostfull(af8),
        .almostempty(ae8), .level(lvl8)
    );

    param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_d5 (
        .clk(clk), .rst(rst), .wr_en(we5), .data_in(din5), .rd_en(re5),
        .data_out(dout5), .rd_valid(vld5), .wr_ack(ack5), .overflow(ovf5),
        .underflow(udf5), .full(full5), .empty(emp5), .almostfull(af5),
        .almostempty(ae5), .level(lvl5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc8(input logic we, input logic re, input logic [15:0] d);
        we8 = we; re8 = re; din8 = d;
        @(posedge clk); #1;
        we8 = 1'b0; re8 = 1'b0;
    endtask

    task automatic cyc5(input logic we, input logic re, input logic [15:0] d);
        we5 = we; re5 = re; din5 = d;
        @(posedge clk); #1;
        we5 = 1'b0; re5 = 1'b0;
    endtask

    // Pop one word from the depth-8 FIFO and check it is the expected one.
    task automatic pop8(input logic [15:0] exp);
`ifdef FIFO_FWFT_EN
        check("pop8_data", dout8, exp);
        check("pop8_vld", vld8, 1);
        cyc8(1'b0, 1'b1, 16'h0);
`else
        cyc8(1'b0, 1'b1, 16'h0);
        check("pop8_data", dout8, exp);
        check("pop8_vld", vld8, 1);
`endif
        check("pop8_udf", udf8, 0);
    endtask

    task automatic reset2(input logic we);
        rst = 1'b1; we8 = we; din8 = 16'h0077;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; we8 = 1'b0;
    endtask

    initial begin
        int n_wr;
        int n_rd;

        // Power-on reset
        #1;
        reset2(1'b0);
        check("rst_lvl", lvl8, 0);
        check("rst_empty", emp8, 1);
        check("rst_full", full8, 0);
        check("rst_af", af8, 0);
        check("rst_ae", ae8, 0);
        check("rst_ack", ack8, 0);
        check("rst_vld", vld8, 0);
`ifndef FIFO_FWFT_EN
        check("rst_dout", dout8, 0);
`endif

        // Fill 1..8 with flag thresholds, then overflow
        for (int k = 1; k <= 8; k++) begin
            cyc8(1'b1, 1'b0, 16'(k));
            check("fill_ack", ack8, 1);
            check("fill_lvl", lvl8, k);
            check("fill_af", af8, (k >= 6));
            check("fill_ae", ae8, (k <= 2));
            check("fill_full", full8, (k == 8));
            check("fill_empty", emp8, 0);
        end
        cyc8(1'b1, 1'b0, 16'h0009);
        check("ovf_flag", ovf8, 1);
        check("ovf_ack", ack8, 0);
        check("ovf_lvl", lvl8, 8);

        // Drain in order
        for (int k = 1; k <= 8; k++) begin
            pop8(16'(k));
            check("drain_lvl", lvl8, 8 - k);
            check("drain_ae", ae8, (8 - k >= 1) && (8 - k <= 2));
            check("drain_empty", emp8, (k == 8));
        end
        cyc8(1'b0, 1'b1, 16'h0);
        check("udf_flag", udf8, 1);
        check("udf_lvl", lvl8, 0);
        check("udf_vld", vld8, 0);
`ifndef FIFO_FWFT_EN
        check("udf_hold", dout8, 16'h0008);
`endif

        // Full with simultaneous read and write
        for (int k = 0; k < 8; k++) cyc8(1'b1, 1'b0, 16'(16'h10 + k));
        check("t3_full", full8, 1);
`ifdef FIFO_FWFT_EN
        check("t3_head", dout8, 16'h0010);
`endif
        cyc8(1'b1, 1'b1, 16'h0099);
        check("t3_ack", ack8, 1);
        check("t3_ovf", ovf8, 0);
        check("t3_lvl", lvl8, 8);
        check("t3_full2", full8, 1);
`ifndef FIFO_FWFT_EN
        check("t3_dout", dout8, 16'h0010);
        check("t3_vld", vld8, 1);
`endif
        for (int k = 1; k < 8; k++) pop8(16'(16'h10 + k));
        pop8(16'h0099);
        check("t3_empty", emp8, 1);

        // Empty with simultaneous read and write
        cyc8(1'b1, 1'b1, 16'hA5A5);
        check("t4_udf", udf8, 1);
        check("t4_ack", ack8, 1);
        check("t4_lvl", lvl8, 1);
`ifdef FIFO_FWFT_EN
        check("t4_vld", vld8, 1);
`else
        check("t4_vld", vld8, 0);
`endif
        pop8(16'hA5A5);
        check("t4_empty", emp8, 1);

`ifdef FIFO_FWFT_EN
        // Fall-through without rd_en
        cyc8(1'b1, 1'b0, 16'h1234);
        check("t6_dout", dout8, 16'h1234);
        check("t6_vld", vld8, 1);
        cyc8(1'b0, 1'b0, 16'h0);
        check("t6_hold", dout8, 16'h1234);
        check("t6_lvl", lvl8, 1);
        cyc8(1'b0, 1'b1, 16'h0);
        check("t6_empty", emp8, 1);
        check("t6_vld0", vld8, 0);
`endif

        // Reset in the middle of traffic, with wr_en held
        for (int k = 0; k < 3; k++) cyc8(1'b1, 1'b0, 16'(16'h31 + k));
        check("t1_pre_lvl", lvl8, 3);
        reset2(1'b1);
        check("t1_lvl", lvl8, 0);
        check("t1_empty", emp8, 1);
        check("t1_ack", ack8, 0);
        check("t1_ovf", ovf8, 0);
        check("t1_udf", udf8, 0);
        check("t1_vld", vld8, 0);
`ifndef FIFO_FWFT_EN
        check("t1_dout", dout8, 0);
`endif
        cyc8(1'b0, 1'b1, 16'h0);
        check("t1_udf_after", udf8, 1);

        // Depth 5: streamed traffic wrapping the pointers
        n_wr = 0;
        n_rd = 0;
        for (int i = 0; i < 5; i++) begin
            cyc5(1'b1, 1'b0, 16'(16'h100 + n_wr));
            n_wr++;
            check("t5_fill_lvl", lvl5, n_wr - n_rd);
        end
        check("t5_full", full5, 1);
        cyc5(1'b1, 1'b0, 16'hDEAD);
        check("t5_ovf", ovf5, 1);
        check("t5_ovf_lvl", lvl5, 5);
        for (int i = 0; i < 15; i++) begin
`ifdef FIFO_FWFT_EN
            check("t5_data", dout5, 16'h100 + n_rd);
`endif
            cyc5(1'b1, 1'b1, 16'(16'h100 + n_wr));
            n_wr++;
`ifndef FIFO_FWFT_EN
            check("t5_data", dout5, 16'h100 + n_rd);
`endif
            n_rd++;
            check("t5_ack", ack5, 1);
            check("t5_lvl", lvl5, 5);
        end
        for (int i = 0; i < 5; i++) begin
`ifdef FIFO_FWFT_EN
            check("t5_drain", dout5, 16'h100 + n_rd);
`endif
            cyc5(1'b0, 1'b1, 16'h0);
`ifndef FIFO_FWFT_EN
            check("t5_drain", dout5, 16'h100 + n_rd);
`endif
            n_rd++;
            check("t5_drain_lvl", lvl5, n_wr - n_rd);
        end
        check("t5_empty", emp5, 1);
        check("t5_count", n_rd, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
